mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYC, default 64: maximum REQ+WAIT cycles without MemAck before the access is aborted; used only under MEM_TIMEOUT_EN.
REQ-002 Clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-003 Rst  in  1  reset, synchronous and active-high.
REQ-004 MemReadIn  in  1  load pending in the EX/MEM register.
REQ-005 MemWriteIn  in  1  store pending in the EX/MEM register.
REQ-006 bytes2LoadIn  in  2  load size: 00 = word, 01 = half, 10 = byte, 11 = word.
REQ-007 bytes2StoreIn  in  2  store size; same encoding as bytes2LoadIn.
REQ-008 LoadSignedIn  in  1  1 = sign-extend a sub-word load, 0 = zero-extend.
REQ-009 ALUResultIn  in  32  byte address of the access.
REQ-010 MemWriteDataIn  in  32  store data, right-aligned.
REQ-011 MemReq  out  1  request to data memory.
REQ-012 MemWe  out  1  1 = write, 0 = read; valid while MemReq = 1.
REQ-013 MemAddr  out  32  word address, {addr[31:2], 2'b00}.
REQ-014 MemBE  out  4  byte enables, little-endian; BE[0] is byte addr[1:0] = 0.
REQ-015 MemWData  out  32  store data shifted onto its byte lanes.
REQ-016 MemAck  in  1  memory completion; MemRData is valid in the same cycle.
REQ-017 MemRData  in  32  read word.
REQ-018 StallOut  out  1  holds PC, IF/ID, ID/EX and EX/MEM.
REQ-019 LoadDataOut  out  32  extracted and extended load result.
REQ-020 LoadValid  out  1  one-cycle pulse; LoadDataOut is valid.
REQ-021 ErrOut  out  1  one-cycle pulse on a misaligned access (or a timeout under MEM_TIMEOUT_EN).

Function
REQ-022 The FSM SHALL have four states: IDLE, REQ, WAIT, DONE.
REQ-023 An access SHALL be pending when MemReadIn or MemWriteIn is 1; if both are 1, the store SHALL take priority and no load SHALL occur.
REQ-024 IDLE, pending and aligned: the controller SHALL latch address, MemWe, MemBE and MemWData, and SHALL go to REQ.
REQ-025 IDLE, pending and misaligned: the controller SHALL go to DONE, SHALL assert ErrOut in DONE, and SHALL issue no MemReq.
  - Misaligned means a half-word access with addr[0] = 1, or a word access with addr[1:0] != 0.
REQ-026 MemReq SHALL be 1 exactly in REQ and WAIT; MemAddr, MemWe, MemBE and MemWData SHALL be stable from REQ until the cycle after MemAck.
REQ-027 REQ with MemAck = 1 SHALL go to DONE; REQ with MemAck = 0 SHALL go to WAIT; WAIT SHALL stay until MemAck = 1, then go to DONE.
REQ-028 On MemAck for a load, the controller SHALL latch the extracted lane(s) and extend them per the latched signed flag into LoadDataOut.
REQ-029 DONE SHALL pulse LoadValid for loads, SHALL always return to IDLE, and SHALL NOT re-arm on the same instruction.
REQ-030 StallOut SHALL be combinational: 1 when (IDLE and pending) or in REQ or WAIT, and 0 in DONE.
  - Minimum occupancy SHALL be 3 cycles (IDLE, REQ, DONE), which is 2 stall cycles.
REQ-031 MemAck SHALL be ignored in IDLE and DONE.
REQ-032 MemBE SHALL be as follows:
  - Byte access: 1 << addr[1:0].
  - Half-word access: 0011 when addr[1] = 0, 1100 when addr[1] = 1.
  - Word access: 1111.
REQ-033 MemWData SHALL be the store data shifted left by 8*addr[1:0].

Reset
REQ-034 Rst SHALL force, on the next edge:
  - State = IDLE.
  - MemReq, MemWe, MemBE, LoadValid and ErrOut = 0.
  - MemAddr, MemWData and LoadDataOut = 0.
REQ-035 Rst asserted in REQ or WAIT SHALL abandon the access; MemReq SHALL be 0 after that edge, and a MemAck arriving afterwards SHALL be ignored.

Configuration
REQ-036 The macro MEM_TIMEOUT_EN, when defined, SHALL add a cycle counter that is cleared on entry to REQ.
  - If TIMEOUT_CYC cycles elapse in REQ/WAIT without MemAck, the FSM SHALL go to DONE with ErrOut = 1, LoadValid = 0 and LoadDataOut = 0.
  - When the macro is undefined, WAIT SHALL persist indefinitely and ErrOut SHALL come from misalignment only.

Verification
REQ-037 Word load at 0x100 with MemAck in REQ and MemRData = 0xDEADBEEF -> StallOut high for 2 cycles; LoadValid pulse with LoadDataOut = 0xDEADBEEF.
REQ-038 Signed byte load at 0x103 with MemRData = 0x80FFFFFF -> MemBE = 1000; LoadDataOut = 0xFFFFFF80.
REQ-039 Half-word store of 0x1234 at 0x202 with MemAck delayed 3 cycles -> MemBE = 1100 and MemWData = 0x12340000, both stable across WAIT; StallOut high for 5 cycles.
REQ-040 Word load at 0x101 -> ErrOut pulses; MemReq never asserts; StallOut high for exactly 1 cycle.
REQ-041 Rst asserted in the second WAIT cycle, then MemAck arrives 1 cycle later -> MemReq = 0 after the edge; no LoadValid; state IDLE.
REQ-042 With MEM_TIMEOUT_EN and TIMEOUT_CYC = 4, no MemAck -> DONE after 4 request cycles; ErrOut = 1 and LoadDataOut = 0.

Source files
------------

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl
// Purpose  : MEM-stage data memory access controller. Turns a pending
//            load/store in the EX/MEM register into a request/acknowledge
//            transaction on the data memory port, generates byte enables and
//            lane-shifted store data, extracts and extends load data, and
//            stalls the pipeline while the access is in flight.
// Revision : 1.0 - initial release
//
// Optional feature macro:
//   MEM_TIMEOUT_EN - abort an access after TIMEOUT_CYC request cycles
//                    without MemAck (ErrOut pulse, LoadDataOut = 0).
//
// Ports:
//   Clk, Rst            clock, synchronous active-high reset
//   MemReadIn/WriteIn   load/store pending in EX/MEM (store wins if both)
//   bytes2LoadIn/Store  access size: 00/11 word, 01 half, 10 byte
//   LoadSignedIn        sign-extend sub-word loads
//   ALUResultIn         byte address
//   MemWriteDataIn      right-aligned store data
//   MemReq/We/Addr/BE/WData  memory request port (registered)
//   MemAck, MemRData    memory completion and read data
//   StallOut            combinational pipeline stall
//   LoadDataOut/LoadValid  load result and one-cycle valid pulse
//   ErrOut              one-cycle error pulse (misalignment / timeout)
// ============================================================================
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        MemReadIn,
  input  logic        MemWriteIn,
  input  logic [1:0]  bytes2LoadIn,
  input  logic [1:0]  bytes2StoreIn,
  input  logic        LoadSignedIn,
  input  logic [31:0] ALUResultIn,
  input  logic [31:0] MemWriteDataIn,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [3:0]  MemBE,
  output logic [31:0] MemWData,
  input  logic        MemAck,
  input  logic [31:0] MemRData,
  output logic        StallOut,
  output logic [31:0] LoadDataOut,
  output logic        LoadValid,
  output logic        ErrOut
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // A zero timeout would abort every access before it could be acknowledged.
  if (TIMEOUT_CYC == 0) begin : g_bad_timeout_cfg
    $error("mem_access_ctrl: TIMEOUT_CYC must be nonzero");
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_t      state_q;
  logic        mem_req_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [3:0]  mem_be_q;
  logic [31:0] mem_wdata_q;
  logic [31:0] load_data_q;
  logic        load_valid_q;
  logic        err_q;
  // Access attributes kept for load extraction when MemAck arrives.
  logic [1:0]  off_q;
  logic        is_byte_q;
  logic        is_half_q;
  logic        signed_q;
  logic        is_load_q;

  // --------------------------------------------------------------------------
  // Request decode (from EX/MEM inputs)
  // --------------------------------------------------------------------------
  logic        pending;
  logic        is_store;
  logic [1:0]  size_sel;
  logic        size_byte;
  logic        size_half;
  logic        misaligned;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;

  assign pending   = MemReadIn | MemWriteIn;
  assign is_store  = MemWriteIn;
  assign size_sel  = is_store ? bytes2StoreIn : bytes2LoadIn;
  assign size_byte = (size_sel == 2'b10);
  assign size_half = (size_sel == 2'b01);

  // Encodings 00 and 11 both mean word.
  assign misaligned = (size_half & ALUResultIn[0]) |
                      (~size_half & ~size_byte & (|ALUResultIn[1:0]));

  always_comb begin
    be_d = 4'b1111;
    if (size_byte) begin
      be_d = 4'b0001 << ALUResultIn[1:0];
    end else if (size_half) begin
      be_d = ALUResultIn[1] ? 4'b1100 : 4'b0011;
    end
  end

  assign wdata_d = MemWriteDataIn << {ALUResultIn[1:0], 3'b000};

  // --------------------------------------------------------------------------
  // Load lane extraction, using the attributes latched at request time
  // --------------------------------------------------------------------------
  logic [31:0] rdata_shifted;
  logic [31:0] load_ext_d;

  assign rdata_shifted = MemRData >> {off_q, 3'b000};

  always_comb begin
    load_ext_d = MemRData;
    if (is_byte_q) begin
      load_ext_d = {{24{signed_q & rdata_shifted[7]}}, rdata_shifted[7:0]};
    end else if (is_half_q) begin
      load_ext_d = {{16{signed_q & rdata_shifted[15]}}, rdata_shifted[15:0]};
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  logic [CNT_W-1:0] cnt_q;
`endif

  // --------------------------------------------------------------------------
  // Access FSM with registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q      <= ST_IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'd0;
      mem_be_q     <= 4'd0;
      mem_wdata_q  <= 32'd0;
      load_data_q  <= 32'd0;
      load_valid_q <= 1'b0;
      err_q        <= 1'b0;
      off_q        <= 2'd0;
      is_byte_q    <= 1'b0;
      is_half_q    <= 1'b0;
      signed_q     <= 1'b0;
      is_load_q    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      // Pulses default low; they are raised only on entry to DONE.
      load_valid_q <= 1'b0;
      err_q        <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pending) begin
            if (misaligned) begin
              err_q   <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              mem_req_q   <= 1'b1;
              mem_we_q    <= is_store;
              mem_addr_q  <= {ALUResultIn[31:2], 2'b00};
              mem_be_q    <= be_d;
              mem_wdata_q <= wdata_d;
              off_q       <= ALUResultIn[1:0];
              is_byte_q   <= size_byte;
              is_half_q   <= size_half;
              signed_q    <= LoadSignedIn;
              is_load_q   <= ~is_store;
`ifdef MEM_TIMEOUT_EN
              cnt_q       <= '0;
`endif
              state_q     <= ST_REQ;
            end
          end
        end

        ST_REQ, ST_WAIT: begin
          if (MemAck) begin
            mem_req_q <= 1'b0;
            state_q   <= ST_DONE;
            if (is_load_q) begin
              load_data_q  <= load_ext_d;
              load_valid_q <= 1'b1;
            end
`ifdef MEM_TIMEOUT_EN
          end else if (cnt_q == CNT_LAST) begin
            mem_req_q   <= 1'b0;
            err_q       <= 1'b1;
            load_data_q <= 32'd0;
            state_q     <= ST_DONE;
          end else begin
            cnt_q   <= cnt_q + CNT_W'(1);
            state_q <= ST_WAIT;
          end
`else
          end else begin
            state_q <= ST_WAIT;
          end
`endif
        end

        // One release cycle: the stall drops so the instruction leaves
        // EX/MEM before IDLE samples the inputs again.
        ST_DONE: begin
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign StallOut    = ((state_q == ST_IDLE) & pending) |
                       (state_q == ST_REQ) | (state_q == ST_WAIT);
  assign MemReq      = mem_req_q;
  assign MemWe       = mem_we_q;
  assign MemAddr     = mem_addr_q;
  assign MemBE       = mem_be_q;
  assign MemWData    = mem_wdata_q;
  assign LoadDataOut = load_data_q;
  assign LoadValid   = load_valid_q;
  assign ErrOut      = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_ctrl
// Purpose  : Self-checking bench for mem_access_ctrl: directed vector table,
//            a reset-during-WAIT sequence, an optional timeout sequence, and
//            randomized accesses checked against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        MemReadIn, MemWriteIn;
  logic [1:0]  bytes2LoadIn, bytes2StoreIn;
  logic        LoadSignedIn;
  logic [31:0] ALUResultIn, MemWriteDataIn;
  logic        MemReq, MemWe;
  logic [31:0] MemAddr;
  logic [3:0]  MemBE;
  logic [31:0] MemWData;
  logic        MemAck;
  logic [31:0] MemRData;
  logic        StallOut;
  logic [31:0] LoadDataOut;
  logic        LoadValid, ErrOut;

  always #5 Clk = ~Clk;

  mem_access_ctrl #(.TIMEOUT_CYC(4)) dut (
    .Clk(Clk), .Rst(Rst),
    .MemReadIn(MemReadIn), .MemWriteIn(MemWriteIn),
    .bytes2LoadIn(bytes2LoadIn), .bytes2StoreIn(bytes2StoreIn),
    .LoadSignedIn(LoadSignedIn), .ALUResultIn(ALUResultIn),
    .MemWriteDataIn(MemWriteDataIn),
    .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemBE(MemBE),
    .MemWData(MemWData), .MemAck(MemAck), .MemRData(MemRData),
    .StallOut(StallOut), .LoadDataOut(LoadDataOut),
    .LoadValid(LoadValid), .ErrOut(ErrOut)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // Transaction-level reference: what a single access must look like.
  function automatic void model(input logic [1:0] sz, input logic sgn,
                                input logic [31:0] addr, wdata, rdata,
                                output logic [3:0] be, output logic [31:0] wd,
                                output logic [31:0] ld, output logic err);
    int nb;
    int off;
    longint unsigned mask;
    longint unsigned v;
    nb   = (sz == 2'b01) ? 2 : (sz == 2'b10) ? 1 : 4;
    off  = int'(addr % 4);
    mask = (64'd1 << (8 * nb)) - 64'd1;
    err  = ((addr % nb) != 0);
    be   = 4'(((1 << nb) - 1) << off);
    wd   = 32'(64'(wdata) << (8 * off));
    v    = (64'(rdata) >> (8 * off)) & mask;
    if (sgn && nb < 4 && v[8*nb-1]) v = v | ~mask;
    ld   = v[31:0];
  endfunction

  // Drives one instruction until its DONE cycle and checks the whole
  // transaction. MemAck is returned on request cycle number dly (0 = REQ).
  task automatic run_txn(input string tag, input logic wr, input logic rd,
                         input logic [1:0] sz, input logic sgn,
                         input logic [31:0] addr, wdata, rdata, input int dly,
                         input logic [3:0] ebe, input logic [31:0] ewd, eld,
                         input int estall, ereq, elv, eerr, input logic chkld);
    int cyc = 0, stall_cnt = 0, req_cnt = 0, lv_cnt = 0, err_cnt = 0;
    logic done = 1'b0;
    logic [31:0] ld_seen = 32'd0;
    MemWriteIn     = wr;
    MemReadIn      = rd;
    bytes2StoreIn  = wr ? sz : 2'($urandom);
    bytes2LoadIn   = wr ? 2'($urandom) : sz;
    LoadSignedIn   = sgn;
    ALUResultIn    = addr;
    MemWriteDataIn = wdata;
    while (!done && cyc < 60) begin
      if (MemReq) begin
        MemAck   = (req_cnt == dly);
        MemRData = MemAck ? rdata : $urandom;
      end else begin
        MemAck   = 1'($urandom_range(0, 1));  // must be ignored outside REQ/WAIT
        MemRData = $urandom;
      end
      #2;
      if (StallOut) stall_cnt++;
      if (MemReq) begin
        req_cnt++;
        chk({tag, ".be"},    {28'd0, MemBE}, {28'd0, ebe});
        chk({tag, ".wdata"}, MemWData, ewd);
        chk({tag, ".addr"},  MemAddr, addr & 32'hFFFF_FFFC);
        chk({tag, ".we"},    {31'd0, MemWe}, {31'd0, wr});
      end
      if (LoadValid) lv_cnt++;
      if (ErrOut) err_cnt++;
      if (cyc > 0 && !StallOut) begin
        done    = 1'b1;
        ld_seen = LoadDataOut;
      end
      @(posedge Clk); #1;
      cyc++;
    end
    MemAck     = 1'b0;
    MemReadIn  = 1'b0;
    MemWriteIn = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL %s.complete: got no DONE within 60 cycles, want completion", tag);
      Rst = 1'b1; @(posedge Clk); #1; Rst = 1'b0;
    end else begin
      chk({tag, ".stall_cycles"}, 32'(stall_cnt), 32'(estall));
      chk({tag, ".req_cycles"},   32'(req_cnt),   32'(ereq));
      chk({tag, ".loadvalid"},    32'(lv_cnt),    32'(elv));
      chk({tag, ".err"},          32'(err_cnt),   32'(eerr));
      if (chkld) chk({tag, ".loaddata"}, ld_seen, eld);
    end
  endtask

  typedef struct {
    logic        wr;
    logic        rd;
    logic [1:0]  sz;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          dly;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] ld;
    logic        err;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    //          wr    rd    sz     sgn   addr          wdata         rdata         d  be     wd            ld            err
    vecs[0] = '{1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0100, 32'h0,       32'hDEAD_BEEF, 0, 4'hF, 32'h0,       32'hDEAD_BEEF, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 2'b10, 1'b1, 32'h0000_0103, 32'h0,       32'h80FF_FFFF, 1, 4'h8, 32'h0,       32'hFFFF_FF80, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0202, 32'h1234,    32'h0,         3, 4'hC, 32'h1234_0000, 32'h0,       1'b0};
    vecs[3] = '{1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0101, 32'h0,       32'h0,         0, 4'h0, 32'h0,       32'h0,         1'b1};
    vecs[4] = '{1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0006, 32'h0,       32'hABCD_1234, 2, 4'hC, 32'h0,       32'h0000_ABCD, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 2'b01, 1'b1, 32'h0000_0004, 32'h0,       32'h0000_8001, 0, 4'h3, 32'h0,       32'hFFFF_8001, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0011, 32'hA5,      32'h0,         0, 4'h2, 32'h0000_A500, 32'h0,       1'b0};
    vecs[7] = '{1'b1, 1'b1, 2'b11, 1'b0, 32'h0000_0040, 32'hCAFE_F00D, 32'h1111_2222, 1, 4'hF, 32'hCAFE_F00D, 32'h0,     1'b0};
    vecs[8] = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0203, 32'h5555,    32'h0,         0, 4'h0, 32'h0,       32'h0,         1'b1};

    Rst = 1'b1; MemReadIn = 1'b0; MemWriteIn = 1'b0;
    bytes2LoadIn = 2'b00; bytes2StoreIn = 2'b00; LoadSignedIn = 1'b0;
    ALUResultIn = 32'd0; MemWriteDataIn = 32'd0; MemAck = 1'b0; MemRData = 32'd0;

    // Reset state
    repeat (2) @(posedge Clk);
    #3;
    chk("rst.memreq",    {31'd0, MemReq},    32'd0);
    chk("rst.memwe",     {31'd0, MemWe},     32'd0);
    chk("rst.membe",     {28'd0, MemBE},     32'd0);
    chk("rst.memaddr",   MemAddr,            32'd0);
    chk("rst.memwdata",  MemWData,           32'd0);
    chk("rst.loaddata",  LoadDataOut,        32'd0);
    chk("rst.loadvalid", {31'd0, LoadValid}, 32'd0);
    chk("rst.err",       {31'd0, ErrOut},    32'd0);
    chk("rst.stall",     {31'd0, StallOut},  32'd0);
    @(posedge Clk); #1;
    Rst = 1'b0;
    @(posedge Clk); #1;

    // Directed vector table
    for (int i = 0; i < 9; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].wr, vecs[i].rd, vecs[i].sz, vecs[i].sgn,
              vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].dly,
              vecs[i].be, vecs[i].wd, vecs[i].ld,
              vecs[i].err ? 1 : 2 + vecs[i].dly,
              vecs[i].err ? 0 : 1 + vecs[i].dly,
              (!vecs[i].wr && !vecs[i].err) ? 1 : 0,
              vecs[i].err ? 1 : 0,
              !vecs[i].wr && !vecs[i].err);
    end

    // Reset in the second WAIT cycle, MemAck one cycle later
    MemReadIn = 1'b1; bytes2LoadIn = 2'b00; LoadSignedIn = 1'b0;
    ALUResultIn = 32'h0000_0080; MemAck = 1'b0;
    #2; chk("rstwait.stall_idle", {31'd0, StallOut}, 32'd1);
    @(posedge Clk); #3; chk("rstwait.req_in_req", {31'd0, MemReq}, 32'd1);
    @(posedge Clk); #3; chk("rstwait.req_in_wait1", {31'd0, MemReq}, 32'd1);
    @(posedge Clk); #1; Rst = 1'b1;
    @(posedge Clk); #1;
    Rst = 1'b0; MemReadIn = 1'b0; MemAck = 1'b1; MemRData = 32'h1357_9BDF;
    #2;
    chk("rstwait.memreq",    {31'd0, MemReq},    32'd0);
    chk("rstwait.stall",     {31'd0, StallOut},  32'd0);
    chk("rstwait.membe",     {28'd0, MemBE},     32'd0);
    chk("rstwait.loadvalid", {31'd0, LoadValid}, 32'd0);
    @(posedge Clk); #1; MemAck = 1'b0;
    #2;
    chk("rstwait.loadvalid2", {31'd0, LoadValid}, 32'd0);
    chk("rstwait.memreq2",    {31'd0, MemReq},    32'd0);
    chk("rstwait.err2",       {31'd0, ErrOut},    32'd0);
    @(posedge Clk); #1;
    // The controller must be back in IDLE and behave normally.
    run_txn("after_rst", 1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0090, 32'h0, 32'h2468_ACE0, 1,
            4'hF, 32'h0, 32'h2468_ACE0, 3, 2, 1, 0, 1'b1);

`ifdef MEM_TIMEOUT_EN
    // No MemAck: abort after 4 request cycles, error with cleared load data.
    run_txn("timeout", 1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0300, 32'h0, 32'hFFFF_FFFF, 1000,
            4'hF, 32'h0, 32'h0, 5, 4, 0, 1, 1'b1);
`endif

    // Randomized accesses against the transaction model
    for (int i = 0; i < 40; i++) begin
      logic        wr, rd, sgn, err;
      logic [1:0]  sz;
      logic [31:0] addr, wdata, rdata, wd, ld;
      logic [3:0]  be;
      int          dly;
      wr    = 1'($urandom_range(0, 1));
      rd    = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      sz    = 2'($urandom);
      sgn   = 1'($urandom_range(0, 1));
      addr  = $urandom;
      if ($urandom_range(0, 3) != 0) addr[1:0] = (sz == 2'b10) ? addr[1:0] :
                                                 (sz == 2'b01) ? {addr[1], 1'b0} : 2'b00;
      wdata = $urandom;
      rdata = $urandom;
      dly   = $urandom_range(0, 3);
      model(sz, sgn, addr, wdata, rdata, be, wd, ld, err);
      run_txn($sformatf("rnd%0d", i), wr, rd, sz, sgn, addr, wdata, rdata, dly,
              be, wd, ld,
              err ? 1 : 2 + dly, err ? 0 : 1 + dly,
              (!wr && !err) ? 1 : 0, err ? 1 : 0, !wr && !err);
    end

    repeat (2) @(posedge Clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
